// File: rtl/mru_ctrl.sv
// -----------------------------------------------------------------------------
// mru_ctrl : arbitrates user writes and periodic display scan reads onto a
// single MRU port.
//
// Writes and scan reads share one set/get strobe pair. A write holds the port
// for one strobe cycle plus WR_HOLD quiet cycles. A read holds it for a strobe
// cycle, a wait cycle and a capture cycle. When both kinds are pending in IDLE,
// the kind that did not win last time is granted.
//
// The display capture pulse (disp_valid) is asserted during the CAPTURE cycle.
// disp_idx/disp_val/disp_cnt are loaded at the end of that cycle, so they
// carry the new entry from the following cycle on.
//
// Optional build macro:
//   MRU_CTRL_WR_EDGE_EN - when defined, a write becomes pending only on a
//                         rising edge of wr_req and stays pending until it is
//                         granted (one write per edge). When undefined, the
//                         wr_req level is the pending request, so holding
//                         wr_req high repeats the write back-to-back.
// -----------------------------------------------------------------------------
module mru_ctrl #(
    parameter int SCAN_PERIOD = 1000,
    parameter int WR_HOLD     = 8,
    parameter int ENTRIES     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_req,
    input  logic [15:0] wr_data,
    output logic        wr_ack,
    input  logic        scan_en,
    output logic        mru_set,
    output logic        mru_get,
    output logic [15:0] mru_data,
    input  logic [19:0] mru_q,
    output logic [2:0]  disp_idx,
    output logic [15:0] disp_val,
    output logic [3:0]  disp_cnt,
    output logic        disp_valid,
    output logic        busy
);

    // Counter widths sized from the parameters; each has at least one bit.
    localparam int TMR_W  = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int HOLD_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SCAN_PERIOD - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WR_HOLD - 1);
    localparam logic [2:0]        IDX_LAST  = 3'(ENTRIES - 1);

    // Encoding of last_grant_reg
    localparam logic GRANT_READ  = 1'b0;
    localparam logic GRANT_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        WR_WAIT = 3'd2,
        READ    = 3'd3,
        RD_WAIT = 3'd4,
        CAPTURE = 3'd5
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Scan timer and the single-deep scan request it raises
    logic [TMR_W-1:0]  tmr_reg;
    logic              scan_pend_reg;
    logic              scan_tc;

    // Arbitration and transaction context
    logic              last_grant_reg;
    logic [15:0]       wr_latch_reg;
    logic [2:0]        scan_idx_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic              wr_pend;
    logic              grant_wr;
    logic              grant_rd;

    // Registered display outputs
    logic [2:0]        disp_idx_reg;
    logic [15:0]       disp_val_reg;
    logic [3:0]        disp_cnt_reg;

    // Terminal count of the scan timer; only meaningful while scanning
    assign scan_tc = scan_en && (tmr_reg == TMR_LAST);

`ifdef MRU_CTRL_WR_EDGE_EN
    logic wr_req_d_reg;
    logic wr_pend_reg;
    logic wr_rise;

    assign wr_rise = wr_req && !wr_req_d_reg;
    assign wr_pend = wr_pend_reg;

    // Remember one rising edge of wr_req until the write it asks for is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_req_d_reg <= 1'b0;
            wr_pend_reg  <= 1'b0;
        end else begin
            wr_req_d_reg <= wr_req;
            wr_pend_reg  <= (wr_pend_reg && !grant_wr) || wr_rise;
        end
    end
`else
    // The request level is the pending write; holding it repeats writes
    assign wr_pend = wr_req;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode, grant arbitration and the strobe/bus outputs
    always_comb begin
        state_next = state_reg;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        mru_set    = 1'b0;
        mru_get    = 1'b0;
        mru_data   = 16'h0000;
        wr_ack     = 1'b0;
        disp_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                // On a tie the kind that lost last time goes first
                if (wr_pend && (!scan_pend_reg || last_grant_reg == GRANT_READ)) begin
                    grant_wr   = 1'b1;
                    state_next = WRITE;
                end else if (scan_pend_reg) begin
                    grant_rd   = 1'b1;
                    state_next = READ;
                end
            end
            WRITE: begin
                mru_set    = 1'b1;
                wr_ack     = 1'b1;
                mru_data   = wr_latch_reg;
                state_next = WR_WAIT;
            end
            WR_WAIT: begin
                if (hold_cnt_reg == HOLD_LAST) begin
                    state_next = IDLE;
                end
            end
            READ: begin
                mru_get    = 1'b1;
                mru_data   = {13'b0, scan_idx_reg};
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                disp_valid = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg != IDLE);

    // Scan timer: free-runs while enabled, parks at zero when disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_reg <= '0;
        end else if (!scan_en) begin
            tmr_reg <= '0;
        end else if (scan_tc) begin
            tmr_reg <= '0;
        end else begin
            tmr_reg <= tmr_reg + TMR_W'(1);
        end
    end

    // Scan request: one bit deep, so extra terminal counts before the grant merge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_pend_reg <= 1'b0;
        end else if (!scan_en) begin
            scan_pend_reg <= 1'b0;
        end else if (scan_tc) begin
            scan_pend_reg <= 1'b1;
        end else if (grant_rd) begin
            scan_pend_reg <= 1'b0;
        end
    end

    // Track which kind was granted last so ties alternate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= GRANT_READ;
        end else if (grant_wr) begin
            last_grant_reg <= GRANT_WRITE;
        end else if (grant_rd) begin
            last_grant_reg <= GRANT_READ;
        end
    end

    // Freeze the write value at grant so wr_data may change afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_latch_reg <= 16'h0000;
        end else if (grant_wr) begin
            wr_latch_reg <= wr_data;
        end
    end

    // Count the quiet cycles after a write; held at zero in every other state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_reg <= '0;
        end else if (state_reg == WR_WAIT) begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
        end else begin
            hold_cnt_reg <= '0;
        end
    end

    // Load the display registers and step to the next entry on capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_idx_reg <= 3'd0;
            disp_val_reg <= 16'h0000;
            disp_cnt_reg <= 4'd0;
            scan_idx_reg <= 3'd0;
        end else if (state_reg == CAPTURE) begin
            disp_idx_reg <= scan_idx_reg;
            disp_val_reg <= mru_q[15:0];
            disp_cnt_reg <= mru_q[19:16];
            scan_idx_reg <= (scan_idx_reg == IDX_LAST) ? 3'd0 : scan_idx_reg + 3'd1;
        end
    end

    assign disp_idx = disp_idx_reg;
    assign disp_val = disp_val_reg;
    assign disp_cnt = disp_cnt_reg;

endmodule

// File: tb/tb_mru_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mru_ctrl : self-checking bench for mru_ctrl.
// A transaction-level reference model predicts every output for every cycle.
// The model tracks the active transaction by kind and by its offset from the
// grant; it does not track FSM states.
// Inputs are driven 1 ns after the rising edge. Outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_mru_ctrl;

    localparam int SP = 10;
    localparam int WH = 8;
    localparam int NE = 8;
`ifdef MRU_CTRL_WR_EDGE_EN
    localparam int EXP_HOLD_SETS = 1;
`else
    localparam int EXP_HOLD_SETS = 4;
`endif

    logic        clk;
    logic        rst_n;
    logic        wr_req;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        scan_en;
    logic        mru_set;
    logic        mru_get;
    logic [15:0] mru_data;
    logic [19:0] mru_q;
    logic [2:0]  disp_idx;
    logic [15:0] disp_val;
    logic [3:0]  disp_cnt;
    logic        disp_valid;
    logic        busy;

    int total;
    int bad;

    logic [43:0] obs;
    logic [43:0] exp_v;

    mru_ctrl #(
        .SCAN_PERIOD(SP),
        .WR_HOLD    (WH),
        .ENTRIES    (NE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .scan_en   (scan_en),
        .mru_set   (mru_set),
        .mru_get   (mru_get),
        .mru_data  (mru_data),
        .mru_q     (mru_q),
        .disp_idx  (disp_idx),
        .disp_val  (disp_val),
        .disp_cnt  (disp_cnt),
        .disp_valid(disp_valid),
        .busy      (busy)
    );

    assign obs = {busy, wr_ack, mru_set, mru_get, mru_data,
                  disp_valid, disp_idx, disp_val, disp_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_rem;      // cycles left in the active transaction (0 = idle)
    int          m_off;      // 1-based offset from the grant
    bit          m_kind_w;   // active transaction is a write
    int          m_tmr;
    bit          m_spend;
    bit          m_wpend;
    bit          m_prev_req;
    bit          m_last_w;
    int          m_idx;
    logic [15:0] m_latch;
    logic [15:0] m_dval;
    logic [3:0]  m_dcnt;
    logic [2:0]  m_didx;

    function automatic void model_reset();
        m_rem = 0; m_off = 0; m_kind_w = 0; m_tmr = 0; m_spend = 0;
        m_wpend = 0; m_prev_req = 0; m_last_w = 0; m_idx = 0;
        m_latch = '0; m_dval = '0; m_dcnt = '0; m_didx = '0;
    endfunction

    function automatic void model_step();
        bit w, r, gw, gr, tc;
        if (!rst_n) begin
            model_reset();
            return;
        end
`ifdef MRU_CTRL_WR_EDGE_EN
        w = m_wpend;
`else
        w = wr_req;
`endif
        r  = m_spend;
        gw = 0;
        gr = 0;
        if (m_rem == 0) begin
            if (w && (!r || !m_last_w)) gw = 1;
            else if (r) gr = 1;
            if (gw) begin
                m_latch = wr_data; m_kind_w = 1; m_rem = 1 + WH; m_off = 1; m_last_w = 1;
            end
            if (gr) begin
                m_kind_w = 0; m_rem = 3; m_off = 1; m_last_w = 0;
            end
        end else begin
            if (!m_kind_w && m_off == 3) begin
                m_dval = mru_q[15:0];
                m_dcnt = mru_q[19:16];
                m_didx = 3'(m_idx);
                m_idx  = (m_idx + 1) % NE;
            end
            m_off++;
            m_rem--;
        end
        tc = scan_en && (m_tmr == SP - 1);
        if (!scan_en) begin
            m_tmr = 0; m_spend = 0;
        end else begin
            m_tmr = tc ? 0 : m_tmr + 1;
            if (tc) m_spend = 1;
            else if (gr) m_spend = 0;
        end
        m_wpend    = (m_wpend && !gw) || (wr_req && !m_prev_req);
        m_prev_req = wr_req;
    endfunction

    function automatic logic [43:0] model_out();
        logic        b, a, s, g, v;
        logic [15:0] d;
        b = (m_rem > 0);
        a = 0; s = 0; g = 0; v = 0; d = '0;
        if (m_rem > 0 && m_off == 1) begin
            if (m_kind_w) begin s = 1; a = 1; d = m_latch; end
            else begin g = 1; d = 16'(m_idx); end
        end
        if (m_rem > 0 && !m_kind_w && m_off == 3) v = 1;
        return {b, a, s, g, d, v, m_didx, m_dval, m_dcnt};
    endfunction

    // Advance one clock: the model consumes the inputs of the closing cycle
    task automatic clock_edge();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Quiet inputs long enough for any transaction to finish
    task automatic settle();
        for (int i = 0; i < 12; i++) begin
            wr_req = 0; scan_en = 0;
            clock_edge();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 0; wr_req = 0; scan_en = 0; wr_data = '0; mru_q = '0;
        model_reset();
        clock_edge();
        clock_edge();
        @(negedge clk);
        total++;
        if (obs !== 44'h0) begin
            bad++; $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        clock_edge();
        rst_n = 1;
    endtask

    task automatic test_write();
        int          set_n, busy_n, ack_ok;
        logic [15:0] set_d;
        settle();
        set_n = 0; busy_n = 0; ack_ok = 1; set_d = '0;
        for (int i = 0; i < 16; i++) begin
            wr_req = (i == 0); wr_data = 16'h00A5; scan_en = 0; mru_q = 20'($urandom);
            @(negedge clk);
            exp_v = model_out();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL write_cycle%0d: got %h expected %h", i, obs, exp_v);
            end
            if (mru_set) begin
                set_n++; set_d = mru_data;
                if (!wr_ack) ack_ok = 0;
            end
            if (busy) busy_n++;
            clock_edge();
        end
        total++;
        if (set_n !== 1) begin bad++; $display("FAIL write_set_count: got %0d expected 1", set_n); end
        total++;
        if (set_d !== 16'h00A5) begin bad++; $display("FAIL write_data: got %h expected 00a5", set_d); end
        total++;
        if (ack_ok !== 1) begin bad++; $display("FAIL write_ack: got %0d expected 1", ack_ok); end
        total++;
        if (busy_n !== 1 + WH) begin bad++; $display("FAIL write_busy_len: got %0d expected %0d", busy_n, 1 + WH); end
    endtask

    task automatic test_scan();
        int first_get, first_valid;
        logic [15:0] gets[$];
        settle();
        first_get = -1; first_valid = -1;
        for (int i = 0; i < 100; i++) begin
            wr_req = 0; scan_en = 1; mru_q = 20'h3_1234; wr_data = 16'($urandom);
            @(negedge clk);
            exp_v = model_out();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL scan_cycle%0d: got %h expected %h", i, obs, exp_v);
            end
            if (mru_get) begin
                gets.push_back(mru_data);
                if (first_get < 0) first_get = i;
            end
            if (first_valid >= 0 && i == first_valid + 1) begin
                total++;
                if (disp_val !== 16'h1234) begin bad++; $display("FAIL scan_disp_val: got %h expected 1234", disp_val); end
                total++;
                if (disp_cnt !== 4'd3) begin bad++; $display("FAIL scan_disp_cnt: got %0d expected 3", disp_cnt); end
                total++;
                if (disp_idx !== 3'd0) begin bad++; $display("FAIL scan_disp_idx: got %0d expected 0", disp_idx); end
            end
            if (disp_valid && first_valid < 0) first_valid = i;
            clock_edge();
        end
        total++;
        if (first_get !== 11) begin bad++; $display("FAIL scan_first_get: got %0d expected 11", first_get); end
        total++;
        if (first_valid !== first_get + 2) begin
            bad++; $display("FAIL scan_valid_latency: got %0d expected %0d", first_valid, first_get + 2);
        end
        total++;
        if (gets.size() !== 9) begin
            bad++; $display("FAIL scan_read_count: got %0d expected 9", gets.size());
        end else begin
            total++;
            if (gets[0] !== 16'd0) begin bad++; $display("FAIL scan_first_idx: got %0d expected 0", gets[0]); end
            total++;
            if (gets[7] !== 16'd7) begin bad++; $display("FAIL scan_idx7: got %0d expected 7", gets[7]); end
            total++;
            if (gets[8] !== 16'd0) begin bad++; $display("FAIL scan_wrap: got %0d expected 0", gets[8]); end
        end
    endtask

    task automatic test_tie();
        int first_set, first_get, gets_early;
        rst_n = 0;
        model_reset();
        clock_edge();
        rst_n = 1;
        first_set = -1; first_get = -1; gets_early = 0;
        for (int i = 0; i < 40; i++) begin
            scan_en = 1;
`ifdef MRU_CTRL_WR_EDGE_EN
            wr_req = (i == 9) || (i == 12);
`else
            wr_req = (i >= 10) && (i <= 20);
`endif
            wr_data = 16'($urandom); mru_q = 20'($urandom);
            @(negedge clk);
            exp_v = model_out();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL tie_cycle%0d: got %h expected %h", i, obs, exp_v);
            end
            if (mru_set && first_set < 0) first_set = i;
            if (mru_get && first_get < 0) first_get = i;
            if (mru_get && i < 29) gets_early++;
            clock_edge();
        end
        total++;
        if (first_set !== 11) begin bad++; $display("FAIL tie_write_first: got %0d expected 11", first_set); end
        total++;
        if (first_get !== 21) begin bad++; $display("FAIL tie_read_after_hold: got %0d expected 21", first_get); end
        total++;
        if (gets_early !== 1) begin bad++; $display("FAIL tie_single_read: got %0d expected 1", gets_early); end
    endtask

    task automatic test_hold();
        int set_n;
        settle();
        set_n = 0;
        for (int i = 0; i < 52; i++) begin
            wr_req = (i < 40); scan_en = 0; wr_data = 16'($urandom); mru_q = 20'($urandom);
            @(negedge clk);
            exp_v = model_out();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL hold_cycle%0d: got %h expected %h", i, obs, exp_v);
            end
            if (mru_set) set_n++;
            clock_edge();
        end
        total++;
        if (set_n !== EXP_HOLD_SETS) begin
            bad++; $display("FAIL hold_set_count: got %0d expected %0d", set_n, EXP_HOLD_SETS);
        end
    endtask

    task automatic test_random();
        logic prev_set, prev_get;
        settle();
        prev_set = 0; prev_get = 0;
        for (int i = 0; i < 600; i++) begin
            wr_req  = ($urandom_range(0, 99) < 15);
            scan_en = ($urandom_range(0, 99) < 92);
            wr_data = 16'($urandom);
            mru_q   = 20'($urandom);
            @(negedge clk);
            exp_v = model_out();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL random_cycle%0d: got %h expected %h", i, obs, exp_v);
            end
            total++;
            if ((mru_set && mru_get) !== 1'b0) begin
                bad++; $display("FAIL random_strobe_overlap%0d: got set=%b get=%b expected one at most", i, mru_set, mru_get);
            end
            total++;
            if (((prev_set && mru_set) || (prev_get && mru_get)) !== 1'b0) begin
                bad++; $display("FAIL random_strobe_len%0d: got repeated strobe expected single cycle", i);
            end
            prev_set = mru_set; prev_get = mru_get;
            clock_edge();
        end
    endtask

    task automatic test_reset_mid();
        int first_get_data, got_get;
        settle();
        for (int i = 0; i < 6; i++) begin
            wr_req = (i == 0); scan_en = 0; wr_data = 16'($urandom); mru_q = 20'($urandom);
            @(negedge clk);
            exp_v = model_out();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL rstmid_pre%0d: got %h expected %h", i, obs, exp_v);
            end
            clock_edge();
        end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_in_wait: got busy=%b expected 1", busy); end
        rst_n = 0;
        model_reset();
        #1;
        total++;
        if (obs !== 44'h0) begin bad++; $display("FAIL rstmid_async: got %h expected 0", obs); end
        @(negedge clk);
        total++;
        if (obs !== 44'h0) begin bad++; $display("FAIL rstmid_outputs: got %h expected 0", obs); end
        clock_edge();
        rst_n = 1;
        first_get_data = -1; got_get = 0;
        for (int i = 0; i < 20; i++) begin
            wr_req = 0; scan_en = 1; wr_data = 16'($urandom); mru_q = 20'($urandom);
            @(negedge clk);
            exp_v = model_out();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL rstmid_post%0d: got %h expected %h", i, obs, exp_v);
            end
            if (mru_get && !got_get) begin
                got_get = 1; first_get_data = int'(mru_data);
            end
            clock_edge();
        end
        total++;
        if (first_get_data !== 0) begin
            bad++; $display("FAIL rstmid_scan_idx: got %0d expected 0", first_get_data);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write();
        test_scan();
        test_tie();
        test_hold();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
